// File: rtl/en_burst_pkg.sv
// Shared types and constants for the enable burst generator.
package en_burst_pkg;

    // Default width of period, burst length and pulse counter.
    localparam int CNT_W = 8;

    // Burst generator control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/reload_cnt.sv
// W-bit down-counter with synchronous load, reload-on-zero and a zero flag.
// Used as the inter-pulse divider of the burst generator.
module reload_cnt
    import en_burst_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    input  logic [W-1:0] reload_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // Load has priority; while running, count down and reload when zero is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= reload_val;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Zero flag marks the cycle in which a pulse is due.
    assign zero = (cnt == '0);

endmodule

// File: rtl/en_burst_gen.sv
// Enable burst generator: on an accepted start, issues burst_len single-cycle
// en pulses spaced (period+1) cycles apart, then strobes done for one cycle.
//
// Request protocol: start is a level request sampled only in IDLE (no ready
// is returned; busy rising on the next edge is the acceptance). stop is an
// abort request sampled only in RUN and FIN and wins over a pulse due in the
// same cycle. Neither input is sampled in any other state.
module en_burst_gen
    import en_burst_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] period,
    input  logic [W-1:0] burst_len,
    output logic         en,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] pulse_cnt
);

    state_t       state;
    logic [W-1:0] period_r;
    logic [W-1:0] len_r;
    logic [W-1:0] div;
    logic         div_zero;
    logic         div_load;
    logic         div_run;
    logic [W-1:0] next_cnt;

    // Divider is loaded with the raw period on acceptance and only runs in RUN;
    // an abort freezes it so the suppressed pulse leaves no trace.
    assign div_load = (state == IDLE) && start;
    assign div_run  = (state == RUN) && !stop;
    assign next_cnt = pulse_cnt + 1'b1;

    reload_cnt #(.W(W)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (div_load),
        .load_val   (period),
        .run        (div_run),
        .reload_val (period_r),
        .cnt        (div),
        .zero       (div_zero)
    );

    // Control FSM with registered en/busy/done and pulse counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_cnt <= '0;
            period_r  <= '0;
            len_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    en   <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        period_r  <= period;
                        len_r     <= burst_len;
                        pulse_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= (burst_len == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (div_zero) begin
                        en        <= 1'b1;
                        pulse_cnt <= next_cnt;
                        if (next_cnt == len_r) begin
                            state <= FIN;
                        end
                    end else begin
                        en <= 1'b0;
                    end
                end
                FIN: begin
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= !stop;
                    state <= IDLE;
                end
                default: begin
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Protocol properties of the generator's own outputs.
    a_en_busy: assert property (@(posedge clk) disable iff (!rst_n) en |-> busy);
    c_en_busy: cover property (@(posedge clk) disable iff (!rst_n) en && busy);

    a_done_idle: assert property (@(posedge clk) disable iff (!rst_n) done |-> (!busy && !en));
    c_done_idle: cover property (@(posedge clk) disable iff (!rst_n) done && !busy && !en);

    a_done_once: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
    c_done_once: cover property (@(posedge clk) disable iff (!rst_n) done ##1 !done);

    a_idle_no_en: assert property (@(posedge clk) disable iff (!rst_n) !busy |-> !en);
    c_idle_no_en: cover property (@(posedge clk) disable iff (!rst_n) !busy && !en);

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) pulse_cnt <= len_r);
    c_cnt_bound: cover property (@(posedge clk) disable iff (!rst_n) (len_r != '0) && (pulse_cnt == len_r));

    a_no_x: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({en, busy, done, pulse_cnt}));
    c_no_x: cover property (@(posedge clk) disable iff (!rst_n) !$isunknown({en, busy, done, pulse_cnt}));

    a_div_range: assert property (@(posedge clk) disable iff (!rst_n) (state == RUN) |-> (div <= period_r));
    c_div_range: cover property (@(posedge clk) disable iff (!rst_n) (state == RUN) && (div == period_r) && (div != '0));

    a_reset_quiet: assert property (@(posedge clk) (!rst_n) |=> (!busy && !en && !done));
    c_reset_quiet: cover property (@(posedge clk) (!rst_n) ##1 (!busy && !en && !done));

endmodule

// File: tb/tb_en_burst_gen.sv
// Directed and randomized bench for en_burst_gen with an arithmetic burst model.
module tb_en_burst_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] period;
    logic [7:0] burst_len;
    logic       en;
    logic       busy;
    logic       done;
    logic [7:0] pulse_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a burst accepted at edge n0 with gap p and length L has
    // pulses at relative edges (p+1)*i for i = 1..L and ends at (p+1)*L + 1.
    bit   act     = 1'b0;
    bit   stopped = 1'b0;
    int   n       = 0;
    int   n0      = 0;
    int   ns      = 0;
    int   mp      = 0;
    int   ml      = 0;
    int   me      = 0;
    logic       exp_en;
    logic       exp_busy;
    logic       exp_done;
    logic [7:0] exp_cnt;
    int   en_seen = 0;

    en_burst_gen #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .burst_len (burst_len),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    // Clock.
    always #5 clk = ~clk;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, want, n);
        end
    endtask

    task automatic model_expect();
        int r;
        if (!act) begin
            exp_en = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_cnt = 8'd0;
        end else if (stopped) begin
            exp_en = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
            exp_cnt = 8'(min2((ns - n0 - 1) / (mp + 1), ml));
        end else begin
            r = n - n0;
            exp_en   = (r > 0) && (r % (mp + 1) == 0) && (r / (mp + 1) <= ml);
            exp_cnt  = 8'(min2(r / (mp + 1), ml));
            exp_busy = (r < me);
            exp_done = (r == me);
        end
    endtask

    task automatic model_edge(input logic s, input logic sp, input logic [7:0] per, input logic [7:0] bl);
        bit in_idle;
        if (!rst_n) begin
            act = 1'b0;
            stopped = 1'b0;
        end else begin
            in_idle = !act || stopped || ((n - n0) > me);
            if (in_idle && s) begin
                act = 1'b1; stopped = 1'b0; n0 = n;
                mp = int'(per); ml = int'(bl); me = (mp + 1) * ml + 1;
            end else if (!in_idle && sp) begin
                stopped = 1'b1; ns = n;
            end
        end
        model_expect();
    endtask

    task automatic check_outputs();
        chk("en", {7'd0, en}, {7'd0, exp_en});
        chk("busy", {7'd0, busy}, {7'd0, exp_busy});
        chk("done", {7'd0, done}, {7'd0, exp_done});
        chk("pulse_cnt", pulse_cnt, exp_cnt);
        if (en === 1'b1) en_seen++;
    endtask

    // Apply inputs, take one clock edge, then check just after the edge.
    task automatic cycle(input logic s, input logic sp, input logic [7:0] per, input logic [7:0] bl);
        start = s; stop = sp; period = per; burst_len = bl;
        @(posedge clk);
        n++;
        model_edge(s, sp, per, bl);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            cycle(1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        int p;
        int l;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; period = 8'd0; burst_len = 8'd0;

        // Reset state.
        cycle(1'b0, 1'b0, 8'd0, 8'd0);
        cycle(1'b1, 1'b0, 8'd3, 8'd4);
        rst_n = 1'b1;
        idle(2);

        // Test 1: period=3, burst_len=4, downstream counter goes 0 -> 4.
        en_seen = 0;
        cycle(1'b1, 1'b0, 8'd3, 8'd4);
        idle(20);
        chk("t1_counter_en", 8'(en_seen), 8'd4);

        // Test 2: period=0, burst_len=5 -> five back-to-back pulses.
        en_seen = 0;
        cycle(1'b1, 1'b0, 8'd0, 8'd5);
        idle(9);
        chk("t2_counter_en", 8'(en_seen), 8'd5);

        // Test 3: zero-length burst -> done only.
        en_seen = 0;
        cycle(1'b1, 1'b0, 8'd7, 8'd0);
        idle(4);
        chk("t3_counter_en", 8'(en_seen), 8'd0);

        // Test 4: abort after the third pulse.
        cycle(1'b1, 1'b0, 8'd2, 8'd10);
        idle(9);
        cycle(1'b0, 1'b1, 8'd0, 8'd0);
        idle(12);
        chk("t4_pulse_cnt", pulse_cnt, 8'd3);

        // Test 5: restart attempts and input changes mid-burst are ignored.
        en_seen = 0;
        cycle(1'b1, 1'b0, 8'd1, 8'd6);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom_range(0, 9)), 8'($urandom_range(0, 9)));
        end
        idle(12);
        chk("t5_counter_en", 8'(en_seen), 8'd6);

        // Test 6: asynchronous reset mid-burst, then a single-pulse burst.
        cycle(1'b1, 1'b0, 8'd4, 8'd8);
        idle(6);
        #2;
        rst_n = 1'b0;
        #1;
        act = 1'b0;
        stopped = 1'b0;
        model_expect();
        check_outputs();
        cycle(1'b1, 1'b0, 8'd0, 8'd3);
        cycle(1'b1, 1'b0, 8'd0, 8'd3);
        rst_n = 1'b1;
        en_seen = 0;
        cycle(1'b1, 1'b0, 8'd0, 8'd1);
        idle(4);
        chk("t6_counter_en", 8'(en_seen), 8'd1);

        // Start and stop together in IDLE: start wins.
        cycle(1'b1, 1'b1, 8'd1, 8'd2);
        idle(7);

        // Randomized bursts with sporadic restart attempts and aborts.
        for (int b = 0; b < 15; b++) begin
            p = $urandom_range(0, 3);
            l = $urandom_range(0, 5);
            cycle(1'b1, 1'b0, 8'(p), 8'(l));
            for (int j = 0; j < (p + 1) * l + 3; j++) begin
                cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                      8'($urandom_range(0, 3)), 8'($urandom_range(0, 5)));
            end
        end
        idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/en_burst_gen.md
Name: en_burst_gen

Overview:
- Upstream enable source for the 8-bit enable counter stage.
- On a start request, generates a burst of burst_len single-cycle enable pulses, one every (period+1) clock cycles.
- Reports progress and completion through busy, done and pulse_cnt.
- Carries embedded SVA assertions and covers for its own protocol.

Parameters:
- W, 8, width of period, burst_len and pulse_cnt.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  burst request; sampled only in IDLE.
- stop  input  1  abort request; sampled in RUN and FIN.
- period  input  W  inter-pulse gap minus one; latched on accepted start.
- burst_len  input  W  number of en pulses in the burst; latched on accepted start.
- en  output  1  enable pulse to the downstream counter.
- busy  output  1  burst in progress.
- done  output  1  one-cycle completion strobe.
- pulse_cnt  output  W  pulses issued in the current or last burst.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Registered outputs: all outputs are registered.
- Reset values: en=0, busy=0, done=0, pulse_cnt=0, div=0, period_r=0, len_r=0, state=IDLE.
- FSM states are IDLE, RUN and FIN.
- IDLE:
  - done deasserts one cycle after being set.
  - On start at edge k: period_r<=period, len_r<=burst_len, div<=period, pulse_cnt<=0, busy<=1.
  - Next state is RUN, or FIN if burst_len==0.
- RUN, at each edge:
  - If div==0: en<=1, pulse_cnt<=pulse_cnt+1, div<=period_r.
  - Otherwise: en<=0, div<=div-1.
  - When the pulse being issued is the len_r-th, the next state is FIN.
- First-pulse latency: the first en is high in the cycle after edge k+period_r+1.
- Pulse spacing: consecutive en rising points are period_r+1 cycles apart. period_r==0 gives en continuously high for len_r cycles.
- FIN, for one cycle: en<=0, done<=1, busy<=0; next state IDLE. done is therefore high exactly one cycle.
- stop in RUN or FIN: next edge en<=0, busy<=0, done stays 0, state<=IDLE, pulse_cnt holds.
  - stop has priority over a pulse due in the same cycle; that pulse is not issued and not counted.
- start while in RUN or FIN is ignored; latched values are unaffected.
- start and stop both high in IDLE: start wins (stop is not sampled in IDLE).
- Input changes: period and burst_len changes during a burst have no effect.
- Count bound: pulse_cnt never exceeds len_r and never wraps; it holds after done until the next accepted start.
- Reset mid-burst: all registers return to reset values immediately; no done is generated.
- Embedded properties (all but the last use disable iff(!rst_n), each with assert and cover):
  - en |-> busy.
  - done |-> !busy && !en.
  - done |=> !done.
  - !busy |-> !en.
  - pulse_cnt <= len_r.
  - no X on any output.
  - (!rst_n) |=> (!busy && !en && !done), without disable iff.

Decomposition:
- Package en_burst_pkg:
  - typedef enum state_t {IDLE, RUN, FIN}.
  - Default width constant CNT_W=8.
- One sub-module, reload_cnt: a W-bit down-counter with load, reload-on-zero and zero flag. It implements div.
- The FSM, pulse counter and assertions remain in en_burst_gen.

Test Plan:
1. period=3, burst_len=4, start one cycle -> en high on cycles k+5, k+9, k+13, k+17 (relative to start edge k); done one cycle later; pulse_cnt=4; a downstream counter_en goes 0->4.
2. period=0, burst_len=5 -> en high 5 consecutive cycles; busy high 6 cycles; done single cycle; pulse_cnt=5.
3. burst_len=0, period=7 -> no en; done high exactly 2 cycles after the start edge; pulse_cnt=0.
4. period=2, burst_len=10; assert stop after 3rd pulse -> en never high again; busy drops next edge; done never asserts; pulse_cnt=3.
5. Burst running (period=1, burst_len=6); pulse start again and change period/burst_len mid-burst -> burst unaffected, exactly 6 pulses with 2-cycle spacing.
6. rst_n low for 2 cycles mid-burst -> outputs 0 asynchronously; after release, start with period=0, burst_len=1 -> single en, then done.
